// File: rtl/key_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer_pkg
// Description : Shared clock and timing constants for the push-button path.
// Revision    : 1.0 - initial release
// ============================================================================
package key_debouncer_pkg;

   localparam int CLK_HZ              = 50_000_000;
   localparam int KEY_CNT_W           = 20;
   localparam int KEY_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
   localparam int KEY_HOLD_CYCLES     = CLK_HZ / 50;    // 20 ms

   // True when value is representable in an unsigned counter of the given width
   function automatic bit cfg_fits(input longint value, input int width);
      return (value >= 1) && (value <= ((longint'(1) << width) - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer_if
// Description : Raw button pins in, debounced level and event pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debouncer_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_state;
   logic [N_BTN-1:0] press_pulse;
   logic [N_BTN-1:0] release_pulse;
   logic [N_BTN-1:0] hold_pulse;

   modport master (
      output btn_raw,
      input  btn_state, press_pulse, release_pulse, hold_pulse
   );

   modport slave (
      input  btn_raw,
      output btn_state, press_pulse, release_pulse, hold_pulse
   );
endinterface
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_channel
// Description : One button: 2-flop sync, stability counter, hold counter, pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_channel #(
   parameter int CNT_W           = 20,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int HOLD_CYCLES     = 1_000_000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic btn_state,
   output logic press_pulse,
   output logic release_pulse,
   output logic hold_pulse
);

   localparam logic             c_IDLE      = ACTIVE_LOW;
   localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_HOLD_MAX  = CNT_W'(HOLD_CYCLES);

   logic             r_s1, r_s2;
   logic             r_state, r_press, r_release, r_hold;
   logic [CNT_W-1:0] r_deb_cnt, r_hold_cnt;
   logic             w_pressed_sync, w_differ, w_accept;

   assign w_pressed_sync = r_s2 ^ ACTIVE_LOW;
   assign w_differ       = (w_pressed_sync != r_state);
   assign w_accept       = w_differ && (r_deb_cnt == c_DEB_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= c_IDLE;
         r_s2 <= c_IDLE;
      end else begin
         r_s1 <= btn_raw;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_press   <= w_accept && !r_state;
         r_release <= w_accept &&  r_state;
         if (!w_differ || w_accept)
            r_deb_cnt <= '0;
         else
            r_deb_cnt <= r_deb_cnt + 1'b1;
         if (w_accept)
            r_state <= ~r_state;
      end
   end

   // While pressed, an accept is a release: clear the hold count and suppress the hold pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_cnt <= '0;
         r_hold     <= 1'b0;
      end else begin
         if (!r_state || w_accept)
            r_hold_cnt <= '0;
         else if (r_hold_cnt != c_HOLD_MAX)
            r_hold_cnt <= r_hold_cnt + 1'b1;
         r_hold <= r_state && !w_accept && (r_hold_cnt == c_HOLD_LAST);
      end
   end

   assign btn_state     = r_state;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign hold_pulse    = r_hold;

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : N independent debounced button channels feeding the PIO in_port.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
   import key_debouncer_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int CNT_W           = KEY_CNT_W,
   parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = KEY_HOLD_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   key_debouncer_if.slave  bus
);

   // Configuration errors are caught at elaboration; nothing is built for them
   if (DEBOUNCE_CYCLES < 2 || !cfg_fits(longint'(DEBOUNCE_CYCLES), CNT_W)) begin : g_bad_debounce
      $error("key_debouncer: DEBOUNCE_CYCLES=%0d outside 2..2^%0d-1", DEBOUNCE_CYCLES, CNT_W);
   end
   if (!cfg_fits(longint'(HOLD_CYCLES), CNT_W)) begin : g_bad_hold
      $error("key_debouncer: HOLD_CYCLES=%0d outside 1..2^%0d-1", HOLD_CYCLES, CNT_W);
   end

   logic [N_BTN-1:0] w_state;
   logic [N_BTN-1:0] w_press;
   logic [N_BTN-1:0] w_release;
   logic [N_BTN-1:0] w_hold;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      key_debounce_channel #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_ch (
         .clk           (clk),
         .reset_n       (reset_n),
         .btn_raw       (bus.btn_raw[i]),
         .btn_state     (w_state[i]),
         .press_pulse   (w_press[i]),
         .release_pulse (w_release[i]),
         .hold_pulse    (w_hold[i])
      );
   end

   assign bus.btn_state     = w_state;
   assign bus.press_pulse   = w_press;
   assign bus.release_pulse = w_release;
   assign bus.hold_pulse    = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debouncer
// Description : Directed stimulus with a window-based reference model and literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debouncer;

   localparam int N    = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 32;
   localparam int CW   = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   int checks = 0;
   int passes = 0;
   int n_press = 0, n_rel = 0, n_hold = 0;

   key_debouncer_if #(.N_BTN(N)) bus ();

   key_debouncer #(
      .N_BTN           (N),
      .CNT_W           (CW),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: pin history, and a level that flips once the last DEB
   // synchronised samples all disagree with it.
   logic [N-1:0] ph[$];
   logic [N-1:0] sh[$];
   logic [N-1:0] lvl, e_press, e_rel, e_hold;
   int           press_at[N];
   int           cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [4*N-1:0] outs();
      return {bus.btn_state, bus.press_pulse, bus.release_pulse, bus.hold_pulse};
   endfunction

   function automatic logic [N-1:0] sig(input int sel);
      case (sel)
         0:       return bus.press_pulse;
         1:       return bus.release_pulse;
         default: return bus.hold_pulse;
      endcase
   endfunction

   task automatic model_reset();
      ph.delete();
      ph.push_back('1);
      ph.push_back('1);
      sh.delete();
      lvl = '0; e_press = '0; e_rel = '0; e_hold = '0;
      cyc = 0;
      for (int c = 0; c < N; c++) press_at[c] = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] pressed;
      bit tog;
      pressed = ~ph[ph.size()-2];
      ph.push_back(bus.btn_raw);
      if (ph.size() > 4) void'(ph.pop_front());
      sh.push_back(pressed);
      if (sh.size() > DEB) void'(sh.pop_front());
      cyc++;
      for (int c = 0; c < N; c++) begin
         tog = (sh.size() == DEB);
         for (int j = 0; j < sh.size(); j++)
            if (sh[j][c] == lvl[c]) tog = 1'b0;
         e_press[c] = tog && !lvl[c];
         e_rel[c]   = tog &&  lvl[c];
         e_hold[c]  = lvl[c] && !tog && ((cyc - press_at[c]) == HOLD);
         if (tog) begin
            lvl[c] = ~lvl[c];
            if (lvl[c]) press_at[c] = cyc;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
         #1;
         if (!reset_n) model_reset();
         chk("cycle_model", 32'(outs()), 32'({lvl, e_press, e_rel, e_hold}));
         n_press += $countones(bus.press_pulse);
         n_rel   += $countones(bus.release_pulse);
         n_hold  += $countones(bus.hold_pulse);
      end
   end

   // Edges until the selected pulse appears on channel ch; -1 on timeout
   task automatic wait_for(input int sel, input int ch, input int bound, output int lat);
      logic [N-1:0] v;
      lat = -1;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         #1;
         v = sig(sel);
         if (v[ch]) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat, lat2, snap_p, snap_r, snap_h;
      bus.btn_raw = '1;
      reset_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", 32'(outs()), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Clean press, long hold, release
      bus.btn_raw[0] = 1'b0;
      wait_for(0, 0, 40, lat);
      chk("clean_press_latency", lat, 10);
      chk("clean_state", 32'(bus.btn_state), 32'h1);
      @(posedge clk); #1;
      chk("press_one_cycle", 32'(bus.press_pulse), 32'h0);
      snap_h = n_hold;
      wait_for(2, 0, 60, lat);
      chk("hold_latency", lat + 1, HOLD);
      repeat (30) @(negedge clk);
      chk("hold_once", n_hold - snap_h, 1);
      bus.btn_raw[0] = 1'b1;
      wait_for(1, 0, 40, lat);
      chk("release_latency", lat, 10);
      repeat (15) @(negedge clk);

      // Bounce: 3-cycle segments never settle long enough
      snap_p = n_press;
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         bus.btn_raw[0] = s[0];
         repeat (2) @(negedge clk);
      end
      chk("bounce_no_pulse", n_press - snap_p, 0);
      @(negedge clk);
      bus.btn_raw[0] = 1'b0;
      wait_for(0, 0, 40, lat);
      chk("bounce_settle_latency", lat, 10);
      @(negedge clk);
      bus.btn_raw[0] = 1'b1;
      repeat (20) @(negedge clk);

      // Glitch of DEB-1 cycles is rejected
      snap_p = n_press; snap_r = n_rel;
      bus.btn_raw[1] = 1'b0;
      repeat (7) @(negedge clk);
      bus.btn_raw[1] = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch7_no_pulse", (n_press - snap_p) + (n_rel - snap_r), 0);
      chk("glitch7_state", 32'(bus.btn_state), 32'h0);

      // Exactly DEB cycles low is accepted, then released DEB cycles later
      bus.btn_raw[1] = 1'b0;
      fork
         begin
            repeat (8) @(negedge clk);
            bus.btn_raw[1] = 1'b1;
         end
         wait_for(0, 1, 40, lat);
      join
      chk("glitch8_press_latency", lat, 10);
      wait_for(1, 1, 40, lat2);
      chk("glitch8_release_gap", lat2, 8);
      repeat (10) @(negedge clk);

      // Short press: released before the hold threshold
      snap_h = n_hold;
      bus.btn_raw[0] = 1'b0;
      wait_for(0, 0, 40, lat);
      chk("short_press_latency", lat, 10);
      repeat (20) @(negedge clk);
      bus.btn_raw[0] = 1'b1;
      repeat (25) @(negedge clk);
      chk("short_no_hold", n_hold - snap_h, 0);

      // Simultaneous press on both channels
      bus.btn_raw = 2'b00;
      wait_for(0, 0, 40, lat);
      chk("simul_press", 32'(bus.press_pulse), 32'h3);
      chk("simul_state", 32'(bus.btn_state), 32'h3);
      @(negedge clk);
      bus.btn_raw = 2'b11;
      repeat (20) @(negedge clk);

      // Reset mid-count, then while pressed and pulsing
      bus.btn_raw[0] = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("reset_mid_count", 32'(outs()), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_for(0, 0, 40, lat);
      chk("press_after_reset", lat, 10);
      reset_n = 1'b0;
      #1;
      chk("reset_drops_pulse", 32'(outs()), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wait_for(0, 0, 40, lat);
      chk("press_after_reset_held", lat, 10);
      @(negedge clk);
      bus.btn_raw[0] = 1'b1;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
